// File: rtl/batch_pkg.sv
// Shared types and defaults for the ping-pong batch controller and its drain
// sub-block.
package batch_pkg;

  localparam int DEFAULT_AW = 12;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    DONE  = 2'd2
  } bank_state_t;

  typedef enum logic {
    C_IDLE = 1'b0,
    C_RUN  = 1'b1
  } comp_state_t;

endpackage

// File: rtl/batch_ctrl_pp_drain.sv
// Result drain for one DONE bank: read counter, one-deep output register
// matching the 1-cycle dst buffer latency, and backpressure handling.
module batch_drain
  import batch_pkg::*;
#(
  parameter int AW = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_bank,
  input  logic [AW-1:0] i_ds,
  input  logic          i_ready,
  output logic          o_v,
  output logic [AW-1:0] o_a,
  output logic          o_bank,
  output logic          o_valid,
  output logic          o_last,
  output logic          o_done
);

  logic [AW-1:0] r_rcnt;
  logic [AW-1:0] r_widx;
  logic          r_valid;

  logic          w_v;
  logic          w_last;
  logic          w_done;

  // A read may only be issued when the output slot is free or being emptied,
  // so the buffer's held output never gets overwritten during a stall.
  assign w_v    = i_start & (r_rcnt < i_ds) & (~r_valid | i_ready);
  assign w_last = r_valid & (r_widx == i_ds - AW'(1));
  assign w_done = w_last & i_ready;

  assign o_v     = w_v;
  assign o_a     = r_rcnt;
  assign o_bank  = i_bank;
  assign o_valid = r_valid;
  assign o_last  = w_last;
  assign o_done  = w_done;

  // Read address counter, presented-word index and output valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rcnt  <= {AW{1'b0}};
      r_widx  <= {AW{1'b0}};
      r_valid <= 1'b0;
    end else begin
      if (w_done) begin
        r_rcnt <= {AW{1'b0}};
      end else if (w_v) begin
        r_rcnt <= r_rcnt + AW'(1);
      end
      if (w_v) begin
        r_widx <= r_rcnt;
      end
      r_valid <= w_v | (r_valid & ~i_ready);
    end
  end

endmodule

// File: rtl/batch_ctrl_pp.sv
// Ping-pong batch controller: overlaps input fill, sample compute and result
// drain on alternate src/dst buffer banks.
module batch_ctrl_pp
  import batch_pkg::*;
#(
  parameter int AW = DEFAULT_AW,
  parameter int NB = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          src_valid,
  input  logic          src_last,
  output logic          src_ready,
  output logic          src_v,
  output logic [AW-1:0] src_a,
  output logic          src_bank,
  output logic          s_init,
  output logic          s_bank,
  input  logic          s_fin,
  output logic          dst_v,
  output logic [AW-1:0] dst_a,
  output logic          dst_bank,
  output logic          dst_valid,
  output logic          dst_last,
  input  logic          dst_ready,
  input  logic [AW-1:0] ss,
  input  logic [AW-1:0] ds,
  output logic          busy,
  output logic          err_last
);

  bank_state_t   r_state [NB];
  logic          r_fp;
  logic          r_cp;
  logic          r_dp;
  logic [AW-1:0] r_fcnt;
  comp_state_t   r_cstate;
  logic          r_err_last;

  logic          w_src_ready;
  logic          w_accept;
  logic          w_word_is_last;
  logic          w_fill_end;
  logic          w_last_bad;
  logic          w_c_start;
  logic          w_c_end;
  logic          w_drain_active;
  logic          w_drain_done;
  logic          w_busy;

  // The sample boundary comes from ss alone; src_last is only cross-checked.
  assign w_src_ready    = run & (r_state[r_fp] == EMPTY) & (ss != {AW{1'b0}});
  assign w_accept       = src_valid & w_src_ready;
  assign w_word_is_last = (r_fcnt == ss - AW'(1));
  assign w_fill_end     = w_accept & w_word_is_last;
  assign w_last_bad     = w_accept & (src_last ^ w_word_is_last);

  assign w_c_start      = (r_cstate == C_IDLE) & (r_state[r_cp] == FULL);
  assign w_c_end        = (r_cstate == C_RUN) & s_fin;
  assign w_drain_active = (r_state[r_dp] == DONE);

  // Any bank holding data, or a partially filled bank, counts as busy.
  always_comb begin
    w_busy = (r_fcnt != {AW{1'b0}});
    for (int i = 0; i < NB; i++) begin
      w_busy = w_busy | (r_state[i] != EMPTY);
    end
  end

  assign src_ready = w_src_ready;
  assign src_v     = w_accept;
  assign src_a     = r_fcnt;
  assign src_bank  = r_fp;
  assign s_init    = w_c_start;
  assign s_bank    = r_cp;
  assign busy      = w_busy;
  assign err_last  = r_err_last;

  // Fill word counter and fill bank pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt <= {AW{1'b0}};
      r_fp   <= 1'b0;
    end else if (w_fill_end) begin
      r_fcnt <= {AW{1'b0}};
      r_fp   <= ~r_fp;
    end else if (w_accept) begin
      r_fcnt <= r_fcnt + AW'(1);
    end
  end

  // Sticky framing error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_last <= 1'b0;
    end else if (w_last_bad) begin
      r_err_last <= 1'b1;
    end
  end

  // Compute sequencer: one s_init per FULL bank, wait for s_fin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cstate <= C_IDLE;
      r_cp     <= 1'b0;
    end else begin
      case (r_cstate)
        C_IDLE: begin
          if (w_c_start) begin
            r_cstate <= C_RUN;
          end
        end
        C_RUN: begin
          if (s_fin) begin
            r_cstate <= C_IDLE;
            r_cp     <= ~r_cp;
          end
        end
        default: begin
          r_cstate <= C_IDLE;
        end
      endcase
    end
  end

  // Drain bank pointer advances once the last word of a sample is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp <= 1'b0;
    end else if (w_drain_done) begin
      r_dp <= ~r_dp;
    end
  end

  // Each pointer only moves its bank out of the state it owns, so the three
  // updates below never land on the same bank in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) begin
        r_state[i] <= EMPTY;
      end
    end else begin
      if (w_fill_end) begin
        r_state[r_fp] <= FULL;
      end
      if (w_c_end) begin
        r_state[r_cp] <= DONE;
      end
      if (w_drain_done) begin
        r_state[r_dp] <= EMPTY;
      end
    end
  end

  batch_drain #(
    .AW(AW)
  ) u_drain (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_drain_active),
    .i_bank  (r_dp),
    .i_ds    (ds),
    .i_ready (dst_ready),
    .o_v     (dst_v),
    .o_a     (dst_a),
    .o_bank  (dst_bank),
    .o_valid (dst_valid),
    .o_last  (dst_last),
    .o_done  (w_drain_done)
  );

endmodule

// File: tb/tb_batch_ctrl_pp.sv
// Randomised bench for batch_ctrl_pp: sample-level reference model (sample
// counters and an expected-word queue) plus directed literal checks.
`timescale 1ns/1ps
module tb_batch_ctrl_pp;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n, run, src_valid, src_last, s_fin, dst_ready;
  logic [AW-1:0] ss, ds;
  logic          src_ready, src_v, src_bank, s_init, s_bank;
  logic          dst_v, dst_bank, dst_valid, dst_last, busy, err_last;
  logic [AW-1:0] src_a, dst_a;

  always #5 clk = ~clk;

  batch_ctrl_pp #(.AW(AW), .NB(2)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .src_valid(src_valid), .src_last(src_last),
    .src_ready(src_ready), .src_v(src_v), .src_a(src_a), .src_bank(src_bank),
    .s_init(s_init), .s_bank(s_bank), .s_fin(s_fin),
    .dst_v(dst_v), .dst_a(dst_a), .dst_bank(dst_bank), .dst_valid(dst_valid),
    .dst_last(dst_last), .dst_ready(dst_ready), .ss(ss), .ds(ds),
    .busy(busy), .err_last(err_last)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model: samples counted through each stage.
  int m_filled, m_started, m_computed, m_drained, m_fcnt, m_rd_idx;
  bit m_run, m_mv, m_err;
  int tag [2];
  int rdata;
  int exp_q [$];

  // Environment knobs and state.
  bit chk_en = 1'b0;
  int src_pct, rdy_pct, fin_min, fin_max, bad_last, inject_left, to_send;
  bit rdy_pattern, spurious;
  int drv_idx, fin_cnt, pat_idx;
  bit n_valid, n_last, n_fin, n_rdy;

  // Observation logs for the directed checks.
  int acc_a_q [$], acc_bank_q [$], acc_first_q [$], sinit_cyc_q [$], sinit_bank_q [$];
  int dbank_q [$], out_val_q [$], drain_done_q [$];
  int last_acc_cyc;

  bit e_rdy, acc, e_init, e_act, e_dv, e_last, e_busy, fin_now, hs;
  int e;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic clear_logs();
    acc_a_q.delete(); acc_bank_q.delete(); acc_first_q.delete(); sinit_cyc_q.delete();
    sinit_bank_q.delete(); dbank_q.delete(); out_val_q.delete(); drain_done_q.delete();
    last_acc_cyc = 0;
  endtask

  task automatic model_reset();
    m_filled = 0; m_started = 0; m_computed = 0; m_drained = 0; m_fcnt = 0; m_rd_idx = 0;
    m_run = 0; m_mv = 0; m_err = 0; tag[0] = 0; tag[1] = 0; rdata = 0; exp_q.delete();
    drv_idx = 0; fin_cnt = 0; pat_idx = 0; to_send = 0; inject_left = 0;
    rdy_pattern = 0; spurious = 0; bad_last = 0;
    clear_logs();
  endtask

  // Single compare process: check at negedge, advance the model, drive after posedge.
  always begin : p_cmp
    @(negedge clk);
    cyc = cyc + 1;
    if (chk_en) begin
      e_rdy = run && ((m_filled - m_drained) < 2) && (ss != 0);
      chk("src_ready", src_ready, e_rdy);
      acc = src_valid && e_rdy;
      chk("src_v", src_v, acc);
      if (acc) begin
        chk("src_a", src_a, m_fcnt);
        chk("src_bank", src_bank, m_filled % 2);
      end
      e_init = !m_run && (m_filled > m_started);
      chk("s_init", s_init, e_init);
      chk("s_bank", s_bank, m_computed % 2);
      e_act = m_computed > m_drained;
      e_dv = e_act && (m_rd_idx < ds) && (!m_mv || dst_ready);
      chk("dst_v", dst_v, e_dv);
      if (e_dv) begin
        chk("dst_a", dst_a, m_rd_idx);
        chk("dst_bank", dst_bank, m_drained % 2);
      end
      chk("dst_valid", dst_valid, m_mv);
      e_last = m_mv && (exp_q.size() > 0) && (exp_q[0] % 2 == 1);
      chk("dst_last", dst_last, e_last);
      e_busy = (m_filled > m_drained) || (m_fcnt != 0);
      chk("busy", busy, e_busy);
      chk("err_last", err_last, m_err);

      if (acc) begin
        if (src_last != (m_fcnt == ss - 1)) m_err = 1;
        if (m_fcnt == ss - 1) begin m_fcnt = 0; m_filled++; end
        else m_fcnt++;
        if (drv_idx == 0) acc_first_q.push_back(cyc);
        acc_a_q.push_back(int'(src_a));
        acc_bank_q.push_back(int'(src_bank));
        last_acc_cyc = cyc;
        if (drv_idx == ss - 1) begin
          drv_idx = 0;
          to_send--;
          if (inject_left > 0) inject_left--;
        end else drv_idx++;
      end

      fin_now = s_fin && m_run;
      if (fin_now) begin
        m_run = 0;
        for (int i = 0; i < ds; i++)
          exp_q.push_back((m_computed * 256 + i) * 2 + ((i == ds - 1) ? 1 : 0));
        m_computed++;
      end
      if (e_init) begin
        m_run = 1;
        sinit_cyc_q.push_back(cyc);
        sinit_bank_q.push_back(int'(s_bank));
        tag[s_bank] = m_started;
        m_started++;
        fin_cnt = $urandom_range(fin_max, fin_min);
      end

      hs = m_mv && dst_ready;
      if (hs) begin
        if (exp_q.size() == 0) chk("dst_extra_word", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("dst_data", rdata, e / 2);
          out_val_q.push_back(rdata);
          if (e % 2 == 1) begin
            m_drained++;
            m_rd_idx = 0;
            drain_done_q.push_back(cyc);
          end
        end
      end
      if (dst_v) rdata = tag[dst_bank] * 256 + int'(dst_a);
      if (e_dv) begin
        if (m_rd_idx == 0) dbank_q.push_back(int'(dst_bank));
        m_rd_idx++;
      end
      m_mv = e_dv || (m_mv && !dst_ready);

      n_valid = (to_send > 0) && ($urandom_range(99, 0) < src_pct);
      n_last = (inject_left > 0) ? (drv_idx == bad_last) : (drv_idx == ss - 1);
      if (m_run) begin
        if (fin_cnt == 0) n_fin = 1;
        else begin fin_cnt--; n_fin = 0; end
      end else n_fin = spurious && ($urandom_range(7, 0) == 0);
      if (rdy_pattern) n_rdy = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
      else n_rdy = ($urandom_range(99, 0) < rdy_pct);
      pat_idx++;
    end else begin
      n_valid = 0; n_last = 0; n_fin = 0; n_rdy = 0;
    end
    @(posedge clk);
    #1;
    src_valid = n_valid; src_last = n_last; s_fin = n_fin; dst_ready = n_rdy;
  end

  task automatic do_reset();
    @(posedge clk); #2;
    chk_en = 0; run = 0; rst_n = 0;
    model_reset();
    @(posedge clk); #2;
    rst_n = 1; chk_en = 1;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    while (!(to_send == 0 && m_fcnt == 0 && m_drained == m_filled && !m_mv) && n < bound) begin
      @(posedge clk);
      n++;
    end
    if (n >= bound) chk({name, "_timeout"}, 1, 0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic set_env(input int s, input int d, input int sp, input int rp,
                         input int fmin, input int fmax, input int n);
    ss = AW'(s); ds = AW'(d); src_pct = sp; rdy_pct = rp;
    fin_min = fmin; fin_max = fmax; run = 1; to_send = n;
  endtask

  initial begin
    int nb, n;
    rst_n = 0; run = 0; src_valid = 0; src_last = 0; s_fin = 0; dst_ready = 0;
    ss = AW'(4); ds = AW'(2);
    src_pct = 100; rdy_pct = 100; fin_min = 0; fin_max = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("reset_flags", int'({src_ready, src_v, src_bank, s_init, s_bank, dst_v, dst_bank,
                             dst_valid, dst_last, busy, err_last}), 0);
    chk("reset_addrs", int'({src_a, dst_a}), 0);
    @(posedge clk); #2;
    rst_n = 1; chk_en = 1;

    // One sample, ss=4, ds=2.
    set_env(4, 2, 100, 100, 3, 3, 1);
    wait_idle("s1", 300);
    chk("s1_accepts", acc_a_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("s1_src_a", acc_a_q[i], i);
    chk("s1_src_bank", acc_bank_q[3], 0);
    chk("s1_init_latency", sinit_cyc_q[0] - last_acc_cyc, 1);
    chk("s1_s_bank", sinit_bank_q[0], 0);
    chk("s1_out_count", out_val_q.size(), 2);
    chk("s1_out0", out_val_q[0], 0);
    chk("s1_out1", out_val_q[1], 1);
    chk("s1_busy_end", busy, 0);

    // Three samples with slow compute.
    do_reset();
    set_env(4, 2, 100, 100, 20, 20, 3);
    wait_idle("s2", 1000);
    chk("s2_inits", sinit_bank_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("s2_s_bank_order", sinit_bank_q[i], i % 2);
      chk("s2_dst_bank_order", dbank_q[i], i % 2);
    end
    chk("s2_third_waits_drain", int'(acc_first_q[2] > drain_done_q[0]), 1);

    // Drain under a 1,0,0,1 ready pattern.
    do_reset();
    rdy_pattern = 1;
    set_env(4, 3, 100, 100, 2, 4, 2);
    wait_idle("s3", 1000);
    chk("s3_out_count", out_val_q.size(), 6);
    for (int i = 0; i < 6; i++) chk("s3_out_word", out_val_q[i], (i / 3) * 256 + (i % 3));
    rdy_pattern = 0;

    // Misplaced src_last, then a well-formed sample.
    do_reset();
    inject_left = 1; bad_last = 2;
    set_env(4, 1, 100, 100, 1, 1, 2);
    wait_idle("s4", 500);
    chk("s4_err_sticky", err_last, 1);
    chk("s4_second_start", acc_a_q[4], 0);
    chk("s4_second_word2", acc_a_q[6], 2);
    chk("s4_out1", out_val_q[1], 256);

    // Pause fill with run low while the other bank computes and drains.
    do_reset();
    set_env(4, 2, 100, 100, 5, 5, 2);
    n = 0;
    while (!(m_filled == 1 && m_fcnt == 2) && n < 200) begin @(posedge clk); n++; end
    #2;
    run = 0;
    nb = acc_a_q.size();
    repeat (25) @(posedge clk);
    #2;
    chk("s5_paused", acc_a_q.size(), nb);
    chk("s5_other_drained", out_val_q.size(), 2);
    run = 1;
    wait_idle("s5", 500);
    chk("s5_resume_addr", acc_a_q[nb], 2);

    // Reset while compute runs and drain is active.
    do_reset();
    set_env(4, 4, 100, 30, 8, 8, 3);
    n = 0;
    while (!(m_run && m_computed > m_drained) && n < 500) begin @(posedge clk); n++; end
    chk("s6_reached_overlap", int'(m_run && m_computed > m_drained), 1);
    #3;
    chk_en = 0; run = 0; rst_n = 0;
    #1;
    chk("s6_async_flags", int'({src_ready, src_v, src_bank, s_init, s_bank, dst_v, dst_bank,
                                dst_valid, dst_last, busy, err_last}), 0);
    chk("s6_async_addrs", int'({src_a, dst_a}), 0);
    model_reset();
    @(posedge clk); #2;
    rst_n = 1; chk_en = 1;
    set_env(4, 2, 100, 100, 2, 2, 1);
    wait_idle("s6", 300);
    chk("s6_restart_addr", acc_a_q[0], 0);
    chk("s6_restart_bank", acc_bank_q[0], 0);

    // Randomised traffic with spurious s_fin pulses.
    spurious = 1;
    for (int r = 0; r < 8; r++) begin
      set_env($urandom_range(5, 1), $urandom_range(5, 1), $urandom_range(100, 30),
              $urandom_range(100, 30), $urandom_range(3, 0), $urandom_range(9, 3),
              $urandom_range(6, 2));
      wait_idle("rand", 3000);
      chk("rand_idle_busy", busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/batch_ctrl_pp.md
Name: batch_ctrl_pp

Overview:
Ping-pong successor to the single-buffer batch controller of the tiny-dnn MNIST accelerator. Manages two src/dst buffer banks, so three activities overlap on alternate banks: filling the next sample from the input stream, computing the current sample, and draining the previous sample's results. Drives the bank-select bits of the src/dst buffers, the s_init/s_fin handshake with sample control, and the AXI-stream-style src/dst ports.

Parameters:
AW, 12, buffer address width; also the width of the ss and ds word counts.
NB, 2, number of banks; fixed at 2 in this generation, with pointers 1 bit wide.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
run  in  1  enable acceptance of new input samples
src_valid  in  1  input word valid
src_last  in  1  input marks the last word of a sample
src_ready  out  1  input word can be accepted
src_v  out  1  src buffer write strobe
src_a  out  AW  src buffer write address
src_bank  out  1  src buffer write bank
s_init  out  1  one-cycle start pulse to sample control
s_bank  out  1  bank that sample control computes on
s_fin  in  1  one-cycle done pulse from sample control
dst_v  out  1  dst buffer read enable
dst_a  out  AW  dst buffer read address
dst_bank  out  1  dst buffer read bank
dst_valid  out  1  output word valid
dst_last  out  1  last output word of a sample
dst_ready  in  1  output word accepted
ss  in  AW  input words per sample; must be >= 1 and stable while busy
ds  in  AW  output words per sample; must be >= 1 and stable while busy
busy  out  1  any bank not EMPTY, or a fill in progress
err_last  out  1  sticky flag: src_last did not coincide with word ss

Behaviour:
- Reset (asynchronous on rst_n low): all outputs 0; every bank EMPTY; fill, compute and drain pointers = 0; counters = 0. Reset mid-operation abandons all samples.
- Per-bank state: EMPTY -> FULL (set by fill) -> DONE (set by compute) -> EMPTY (set by drain).
- Each pointer touches only the bank in the state its FSM expects, so same-cycle updates never target the same bank.
- Fill:
  - src_ready = run & state[fp]==EMPTY & ss!=0.
  - On accept (src_valid & src_ready): src_v=1, src_a=fcnt and src_bank=fp, all combinational in the accept cycle; then fcnt++.
  - When the accepted word has fcnt==ss-1: fcnt<=0, state[fp]<=FULL, fp toggles.
  - src_last is checked against the counted last word; any mismatch sets err_last, which clears only on reset. The sample boundary is set by ss, never by src_last.
  - run low pauses the fill with fcnt held; it does not affect compute or drain.
- Compute FSM, states IDLE/RUN:
  - IDLE and state[cp]==FULL: s_init=1 for one cycle, s_bank=cp, go to RUN.
  - RUN: s_bank holds cp; on s_fin, state[cp]<=DONE, cp toggles, return to IDLE.
  - Earliest next s_init is the cycle after s_fin. s_fin while IDLE is ignored.
- Drain, with a 1-cycle dst buffer read latency; the buffer output holds when dst_v=0:
  - Active while state[dp]==DONE.
  - dst_v = active & rcnt<ds & (~dst_valid | dst_ready); dst_a=rcnt, dst_bank=dp; rcnt++ on dst_v.
  - dst_valid <= dst_v | (dst_valid & ~dst_ready).
  - dst_last = dst_valid & (word index == ds-1).
  - Handshake on the last word: rcnt<=0, state[dp]<=EMPTY, dp toggles.
  - Stall: while dst_valid & ~dst_ready, dst_v=0, and dst_valid and dst_last hold.
  - Throughput: 1 word/cycle under continuous dst_ready.
- busy = |(state != EMPTY) | fcnt!=0.

Decomposition:
- Package batch_pkg: bank_state_t enum {EMPTY, FULL, DONE}; compute-state enum {C_IDLE, C_RUN}; default AW.
- Sub-module batch_drain: read counter, valid/last pipeline and stall logic. It takes start/bank inputs and returns a done pulse.
- Fill, compute and the bank-state array live in batch_ctrl_pp.

Test Plan:
- ss=4, ds=2, one sample, dst_ready=1 → src_a 0..3 on bank 0; s_init one cycle after the 4th accept with s_bank=0; after s_fin, dst_a 0,1 on bank 0, dst_last on word 1; busy returns to 0.
- Three back-to-back samples, ss=4, s_fin held off 20 cycles → samples 1 and 2 fill banks 0 and 1; src_ready low for sample 3 until bank 0 drains; bank order is 0,1,0 on s_bank and dst_bank.
- Drain with dst_ready toggling 1,0,0,1,... and ds=3 → no word dropped or duplicated; dst_valid and word value held through stalls; dst_v=0 during a stall.
- ss=4, src_last on word 2, then a correct sample → err_last set and still 1 after the second sample; boundaries stay at 4 words.
- run dropped after 2 words, then raised → fill resumes at src_a=2; an in-flight compute/drain on the other bank completes meanwhile.
- rst_n pulsed low while compute is RUN and drain is active → all outputs 0 asynchronously, banks EMPTY; the next sample starts at bank 0, src_a 0.
